config_chain_loader: RTL and testbench

- Drives the serial configuration chain of the CGRA from a word-wide stream. It is the transmit/readback end of the ConfigCell shift-chain protocol.
- Serializes CHAIN_LEN configuration bits into the head of the chain and produces a per-cycle shift enable. Integration feeds that enable to the clock gate that produces the chain's shift clock.
- Optionally captures the bits falling out of the chain tail and returns them as words, so software can read back and verify the previous configuration.

---
 rtl/config_chain_loader.sv | 155 +++++++++++++++
 tb/tb_config_chain_loader.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/config_chain_loader.sv
`default_nettype none
// =============================================================================
// config_chain_loader : serializes config words into the CGRA shift chain and
// optionally returns the bits falling out of the tail as readback words.
// Rev 1.0
// =============================================================================
module config_chain_loader #(
  parameter int CHAIN_LEN = 64,
  parameter int WORD_W    = 32
) (
  input  logic              Config_Clock,
  input  logic              Config_Reset_n,
  input  logic              Start,
  input  logic              Readback_En,
  output logic              Busy,
  output logic              Done,
  input  logic [WORD_W-1:0] Wr_Data,
  input  logic              Wr_Valid,
  output logic              Wr_Ready,
  output logic [WORD_W-1:0] Rd_Data,
  output logic              Rd_Valid,
  input  logic              Rd_Ready,
  output logic              Chain_ShiftEn,
  output logic              Chain_Data,
  input  logic              Chain_Return
);

  localparam int NW        = (CHAIN_LEN + WORD_W - 1) / WORD_W;
  localparam int LAST_BITS = CHAIN_LEN - (NW - 1) * WORD_W;
  localparam int BC_W      = $clog2(CHAIN_LEN + 1);
  localparam int WC_W      = $clog2(NW + 1);
  localparam int NB_W      = $clog2(WORD_W + 1);
  localparam int RI_W      = $clog2(WORD_W);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DRAIN = 2'd2,
    ST_FIN   = 2'd3
  } state_t;

  state_t            r_state;
  state_t            w_next;
  logic              r_rb_en;
  logic [WORD_W-1:0] r_buf;
  logic              r_buf_full;
  logic [NB_W-1:0]   r_buf_left;
  logic [WC_W-1:0]   r_words;
  logic [BC_W-1:0]   r_bit_cnt;
  logic [RI_W-1:0]   r_rd_idx;
  logic [WORD_W-1:0] r_rd_data;
  logic              r_rd_valid;

  logic w_start;
  logic w_wr_hs;
  logic w_rd_hs;
  logic w_shift;
  logic w_final_bit;
  logic w_last_shift;
  logic w_rd_word_end;

  assign w_start       = (r_state == ST_IDLE) && Start;
  assign Wr_Ready      = (r_state == ST_SHIFT) && !r_buf_full && (r_words < WC_W'(NW));
  assign w_wr_hs       = Wr_Valid && Wr_Ready;
  // Purely a function of flops so the clock-gate enable never sees an input glitch.
  assign Chain_ShiftEn = (r_state == ST_SHIFT) && r_buf_full && !(r_rb_en && r_rd_valid);
  assign w_shift       = Chain_ShiftEn;
  assign w_final_bit   = (r_bit_cnt == BC_W'(CHAIN_LEN - 1));
  assign w_last_shift  = w_shift && w_final_bit;
  assign w_rd_hs       = r_rd_valid && Rd_Ready;
  assign w_rd_word_end = (r_rd_idx == RI_W'(WORD_W - 1)) || w_final_bit;

  assign Chain_Data = r_buf[0];
  assign Rd_Data    = r_rd_data;
  assign Rd_Valid   = r_rd_valid;
  assign Busy       = (r_state != ST_IDLE);
  assign Done       = (r_state == ST_FIN);

  always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
    if (!Config_Reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE:  if (Start) w_next = ST_SHIFT;
      ST_SHIFT: if (w_last_shift) w_next = r_rb_en ? ST_DRAIN : ST_FIN;
      ST_DRAIN: if (w_rd_hs) w_next = ST_FIN;
      ST_FIN:   w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge Config_Clock or negedge Config_Reset_n) begin
    if (!Config_Reset_n) begin
      r_rb_en    <= 1'b0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_buf_left <= '0;
      r_words    <= '0;
      r_bit_cnt  <= '0;
      r_rd_idx   <= '0;
      r_rd_data  <= '0;
      r_rd_valid <= 1'b0;
    end else if (w_start) begin
      r_rb_en    <= Readback_En;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_buf_left <= '0;
      r_words    <= '0;
      r_bit_cnt  <= '0;
      r_rd_idx   <= '0;
      r_rd_valid <= 1'b0;
    end else begin
      if (w_wr_hs) begin
        r_buf      <= Wr_Data;
        r_buf_full <= 1'b1;
        r_buf_left <= (r_words == WC_W'(NW - 1)) ? NB_W'(LAST_BITS) : NB_W'(WORD_W);
        r_words    <= r_words + WC_W'(1);
      end else if (w_shift) begin
        // Zero the buffer once drained so ignored upper bits never reach the chain.
        if (r_buf_left == NB_W'(1)) begin
          r_buf      <= '0;
          r_buf_full <= 1'b0;
        end else begin
          r_buf <= r_buf >> 1;
        end
        r_buf_left <= r_buf_left - NB_W'(1);
        r_bit_cnt  <= r_bit_cnt + BC_W'(1);
      end

      if (w_shift && r_rb_en) begin
        if (r_rd_idx == '0) begin
          r_rd_data <= {{(WORD_W-1){1'b0}}, Chain_Return};
        end else begin
          r_rd_data[r_rd_idx] <= Chain_Return;
        end
        if (w_rd_word_end) begin
          r_rd_valid <= 1'b1;
          r_rd_idx   <= '0;
        end else begin
          r_rd_idx <= r_rd_idx + RI_W'(1);
        end
      end else if (w_rd_hs) begin
        r_rd_valid <= 1'b0;
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_config_chain_loader.sv
`default_nettype none
// =============================================================================
// tb_config_chain_loader : directed self-checking bench with a 40-cell chain model.
// Rev 1.0
// =============================================================================
module tb_config_chain_loader;

  localparam int CL = 40;
  localparam int WW = 32;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          start = 1'b0;
  logic          readback_en = 1'b0;
  logic          busy;
  logic          done;
  logic [WW-1:0] wr_data = '0;
  logic          wr_valid = 1'b0;
  logic          wr_ready;
  logic [WW-1:0] rd_data;
  logic          rd_valid;
  logic          rd_ready = 1'b0;
  logic          shift_en;
  logic          chain_data;
  logic          chain_return;

  logic [CL-1:0] chain = '0;

  int checks = 0;
  int passed = 0;
  int timeouts = 0;
  int stall_req = 0;

  // Monitor-owned state
  int          n_shift = 0;
  int          n_done = 0;
  int          stall_left = 0;
  int          stall_seen = 0;
  int          stall_changed = 0;
  int          stall_shift_bad = 0;
  logic [63:0] shifted = '0;
  logic [31:0] stall_ref = '0;
  logic        busy_prev = 1'b0;
  logic        done_prev = 1'b0;
  logic        busy_after_done = 1'b1;
  logic [31:0] rd_log[$];

  config_chain_loader #(.CHAIN_LEN(CL), .WORD_W(WW)) dut (
    .Config_Clock   (clk),
    .Config_Reset_n (rst_n),
    .Start          (start),
    .Readback_En    (readback_en),
    .Busy           (busy),
    .Done           (done),
    .Wr_Data        (wr_data),
    .Wr_Valid       (wr_valid),
    .Wr_Ready       (wr_ready),
    .Rd_Data        (rd_data),
    .Rd_Valid       (rd_valid),
    .Rd_Ready       (rd_ready),
    .Chain_ShiftEn  (shift_en),
    .Chain_Data     (chain_data),
    .Chain_Return   (chain_return)
  );

  always #5 clk = ~clk;

  // Chain: head at index CL-1, tail at index 0.
  always @(posedge clk) if (shift_en) chain <= {chain_data, chain[CL-1:1]};
  assign chain_return = chain[0];

  always @(negedge clk) begin
    if (busy && !busy_prev) begin
      n_shift = 0; n_done = 0; shifted = '0; rd_log.delete();
      stall_left = stall_req; stall_seen = 0; stall_changed = 0; stall_shift_bad = 0;
    end
    busy_prev = busy;
    if (shift_en) begin
      if (n_shift < 64) shifted[n_shift] = chain_data;
      n_shift++;
    end
    if (done) n_done++;
    if (done_prev) busy_after_done = busy;
    done_prev = done;
    if (rd_valid) begin
      if (stall_left > 0) begin
        if (stall_seen == 0) stall_ref = rd_data;
        else if (rd_data !== stall_ref) stall_changed++;
        if (shift_en) stall_shift_bad++;
        stall_seen++;
        stall_left--;
        rd_ready = 1'b0;
      end else begin
        rd_ready = 1'b1;
        rd_log.push_back(rd_data);
      end
    end else begin
      rd_ready = 1'b0;
    end
  end

  task automatic start_load(input logic rb);
    start = 1'b1; readback_en = rb;
    @(negedge clk);
    start = 1'b0; readback_en = 1'b0;
  endtask

  task automatic send_word(input logic [31:0] w);
    wr_data = w; wr_valid = 1'b1;
    for (int i = 0; i < 200 && !wr_ready; i++) @(negedge clk);
    if (!wr_ready) timeouts++;
    @(negedge clk);
    wr_valid = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    if (!done) timeouts++;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_reset();
    wr_valid = 1'b1;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, wr_ready, rd_valid, shift_en, chain_data} !== 6'b0)
      $display("FAIL reset_outputs: got %b want 000000", {busy, done, wr_ready, rd_valid, shift_en, chain_data}); else passed++;
    checks++; if (rd_data !== 32'h0) $display("FAIL reset_rd_data: got %h want 0", rd_data); else passed++;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks++; if (wr_ready !== 1'b0) $display("FAIL idle_wr_ready: got %b want 0", wr_ready); else passed++;
    checks++; if (busy !== 1'b0) $display("FAIL idle_busy: got %b want 0", busy); else passed++;
    wr_valid = 1'b0;
  endtask

  task automatic test_load_basic();
    start_load(1'b0);
    send_word(32'hDEADBEEF);
    checks++; if ({shift_en, chain_data} !== 2'b11)
      $display("FAIL first_shift_latency: got %b want 11", {shift_en, chain_data}); else passed++;
    send_word(32'hFFFFFFA5);
    wait_done();
    checks++; if (n_shift !== 40) $display("FAIL basic_shift_count: got %0d want 40", n_shift); else passed++;
    checks++; if (shifted[39:0] !== 40'hA5DEADBEEF)
      $display("FAIL basic_chain_data: got %h want a5deadbeef", shifted[39:0]); else passed++;
    checks++; if (chain !== 40'hA5DEADBEEF) $display("FAIL basic_image: got %h want a5deadbeef", chain); else passed++;
    checks++; if (n_done !== 1) $display("FAIL basic_done_pulses: got %0d want 1", n_done); else passed++;
    checks++; if (busy_after_done !== 1'b0) $display("FAIL basic_busy_after_fin: got %b want 0", busy_after_done); else passed++;
    checks++; if (rd_log.size() !== 0) $display("FAIL basic_no_rd: got %0d words want 0", rd_log.size()); else passed++;
    checks++; if (timeouts !== 0) $display("FAIL basic_timeout: got %0d want 0", timeouts); else passed++;
  endtask

  task automatic test_readback();
    start_load(1'b1);
    send_word(32'h12345678);
    send_word(32'h0000003C);
    wait_done();
    checks++; if (rd_log.size() !== 2) $display("FAIL rb_word_count: got %0d want 2", rd_log.size()); else passed++;
    checks++; if ((rd_log.size() > 0 ? rd_log[0] : 32'hx) !== 32'hDEADBEEF)
      $display("FAIL rb_word0: got %h want deadbeef", rd_log.size() > 0 ? rd_log[0] : 32'hx); else passed++;
    checks++; if ((rd_log.size() > 1 ? rd_log[1] : 32'hx) !== 32'h000000A5)
      $display("FAIL rb_word1: got %h want 000000a5", rd_log.size() > 1 ? rd_log[1] : 32'hx); else passed++;
    checks++; if (chain !== 40'h3C12345678) $display("FAIL rb_image: got %h want 3c12345678", chain); else passed++;
    checks++; if (n_done !== 1) $display("FAIL rb_done_pulses: got %0d want 1", n_done); else passed++;
    checks++; if (timeouts !== 0) $display("FAIL rb_timeout: got %0d want 0", timeouts); else passed++;
  endtask

  task automatic test_wr_gap();
    int gap_bad = 0;
    start_load(1'b0);
    send_word(32'hCAFEF00D);
    for (int i = 0; i < 200 && !wr_ready; i++) @(negedge clk);
    for (int k = 0; k < 5; k++) begin
      if (shift_en) gap_bad++;
      @(negedge clk);
    end
    checks++; if (gap_bad !== 0) $display("FAIL gap_shift_en: got %0d high cycles want 0", gap_bad); else passed++;
    checks++; if (n_shift !== 32) $display("FAIL gap_bit_count: got %0d want 32", n_shift); else passed++;
    send_word(32'h0000005A);
    wait_done();
    checks++; if (shifted[39:0] !== 40'h5ACAFEF00D)
      $display("FAIL gap_chain_data: got %h want 5acafef00d", shifted[39:0]); else passed++;
    checks++; if (chain !== 40'h5ACAFEF00D) $display("FAIL gap_image: got %h want 5acafef00d", chain); else passed++;
    checks++; if (n_shift !== 40) $display("FAIL gap_shift_count: got %0d want 40", n_shift); else passed++;
  endtask

  task automatic test_rd_stall();
    stall_req = 10;
    start_load(1'b1);
    send_word(32'h0F1E2D3C);
    send_word(32'h00000077);
    wait_done();
    stall_req = 0;
    checks++; if (stall_seen !== 10) $display("FAIL stall_cycles: got %0d want 10", stall_seen); else passed++;
    checks++; if (stall_shift_bad !== 0) $display("FAIL stall_shift_en: got %0d want 0", stall_shift_bad); else passed++;
    checks++; if (stall_changed !== 0) $display("FAIL stall_rd_stable: got %0d changes want 0", stall_changed); else passed++;
    checks++; if ((rd_log.size() > 0 ? rd_log[0] : 32'hx) !== 32'hCAFEF00D)
      $display("FAIL stall_word0: got %h want cafef00d", rd_log.size() > 0 ? rd_log[0] : 32'hx); else passed++;
    checks++; if ((rd_log.size() > 1 ? rd_log[1] : 32'hx) !== 32'h0000005A)
      $display("FAIL stall_word1: got %h want 0000005a", rd_log.size() > 1 ? rd_log[1] : 32'hx); else passed++;
    checks++; if (chain !== 40'h770F1E2D3C) $display("FAIL stall_image: got %h want 770f1e2d3c", chain); else passed++;
    checks++; if (n_shift !== 40) $display("FAIL stall_shift_count: got %0d want 40", n_shift); else passed++;
  endtask

  task automatic test_reset_midload();
    int cnt = 0;
    start_load(1'b0);
    send_word(32'h11111111);
    for (int i = 0; i < 200 && cnt < 17; i++) begin
      if (shift_en) cnt++;
      @(negedge clk);
    end
    checks++; if (cnt !== 17) $display("FAIL mid_reach_17: got %0d want 17", cnt); else passed++;
    #2 rst_n = 1'b0;
    #1;
    checks++; if ({busy, done, wr_ready, rd_valid, shift_en, chain_data} !== 6'b0)
      $display("FAIL mid_reset_outputs: got %b want 000000", {busy, done, wr_ready, rd_valid, shift_en, chain_data}); else passed++;
    checks++; if (rd_data !== 32'h0) $display("FAIL mid_reset_rd_data: got %h want 0", rd_data); else passed++;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    start_load(1'b0);
    send_word(32'h89ABCDEF);
    send_word(32'h00000042);
    wait_done();
    checks++; if (chain !== 40'h4289ABCDEF) $display("FAIL mid_reload_image: got %h want 4289abcdef", chain); else passed++;
    checks++; if (n_shift !== 40) $display("FAIL mid_reload_shifts: got %0d want 40", n_shift); else passed++;
    checks++; if (timeouts !== 0) $display("FAIL final_timeouts: got %0d want 0", timeouts); else passed++;
  endtask

  initial begin
    test_reset();
    test_load_basic();
    test_readback();
    test_wr_gap();
    test_rd_stall();
    test_reset_midload();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
`default_nettype wire
